// File: rtl/gpr_multicycle_exec.sv
// Multicycle execution core: GPR file, ALU with {V,C,S,Z} flags and a shift-add multiplier.
// Accepts one decoded instruction over valid/ready and retires it through IDLE->OPER->EXEC->WB.
module gpr_multicycle_exec #(
    parameter  int DATA_W  = 16,
    parameter  int NUM_GPR = 32,
    parameter  int IMM_W   = 16,
    localparam int RA_W    = $clog2(NUM_GPR)
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        instr_op,
    input  logic [RA_W-1:0]   instr_rdst,
    input  logic [RA_W-1:0]   instr_rsrc1,
    input  logic [RA_W-1:0]   instr_rsrc2,
    input  logic              instr_imm_mode,
    input  logic [IMM_W-1:0]  instr_imm,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] sgpr,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPER,
        S_EXEC,
        S_WB
    } state_t;

    state_t              state;
    logic [4:0]          op_q;
    logic [RA_W-1:0]     rdst_q;
    logic [RA_W-1:0]     rsrc1_q;
    logic [RA_W-1:0]     rsrc2_q;
    logic                imm_mode_q;
    logic [IMM_W-1:0]    imm_q;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [2*DATA_W-1:0] prod;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   gpr [NUM_GPR];

    logic [DATA_W-1:0]   b_sel;
    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;
    logic [DATA_W:0]     mul_add;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_v;
    logic [3:0]          alu_flags;
    logic [DATA_W-1:0]   mul_hi;
    logic [3:0]          mul_flags;
    logic                op_illegal;

    assign dbg_data   = gpr[dbg_addr];
    assign op_illegal = (op_q > OP_NOT);
    assign b_sel      = imm_mode_q ? DATA_W'(imm_q) : gpr[rsrc2_q];

    // Subtraction is A + ~B + 1, so a carry out means "no borrow".
    assign sum_ext  = {1'b0, opa} + {1'b0, opb};
    assign diff_ext = {1'b0, opa} + {1'b0, ~opb} + {{DATA_W{1'b0}}, 1'b1};

    // One shift-add step: the multiplier sits in the low half of prod and is consumed LSB first.
    assign mul_add  = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, (prod[0] ? opa : {DATA_W{1'b0}})};

    assign mul_hi    = prod[2*DATA_W-1:DATA_W];
    assign mul_flags = {(mul_hi != '0), (mul_hi != '0), prod[2*DATA_W-1], (prod == '0)};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_MOVSGPR: alu_res = sgpr;
            OP_MOV:     alu_res = opb;
            OP_ADD: begin
                alu_res = sum_ext[DATA_W-1:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (opa[DATA_W-1] == opb[DATA_W-1]) &&
                          (sum_ext[DATA_W-1] != opa[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[DATA_W-1:0];
                alu_c   = diff_ext[DATA_W];
                alu_v   = (opa[DATA_W-1] != opb[DATA_W-1]) &&
                          (diff_ext[DATA_W-1] != opa[DATA_W-1]);
            end
            OP_OR:      alu_res = opa | opb;
            OP_AND:     alu_res = opa & opb;
            OP_XOR:     alu_res = opa ^ opb;
            OP_XNOR:    alu_res = ~(opa ^ opb);
            OP_NAND:    alu_res = ~(opa & opb);
            OP_NOR:     alu_res = ~(opa | opb);
            OP_NOT:     alu_res = ~opa;
            default:    alu_res = '0;
        endcase
    end

    assign alu_flags = {alu_v, alu_c, alu_res[DATA_W-1], (alu_res == '0)};

    // Reset clears architectural state at once, so an in-flight instruction never reaches WB.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            illegal     <= 1'b0;
            flags       <= '0;
            sgpr        <= '0;
            op_q        <= '0;
            rdst_q      <= '0;
            rsrc1_q     <= '0;
            rsrc2_q     <= '0;
            imm_mode_q  <= 1'b0;
            imm_q       <= '0;
            opa         <= '0;
            opb         <= '0;
            prod        <= '0;
            cnt         <= '0;
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q        <= instr_op;
                        rdst_q      <= instr_rdst;
                        rsrc1_q     <= instr_rsrc1;
                        rsrc2_q     <= instr_rsrc2;
                        imm_mode_q  <= instr_imm_mode;
                        imm_q       <= instr_imm;
                        instr_ready <= 1'b0;
                        state       <= S_OPER;
                    end
                end
                S_OPER: begin
                    opa   <= gpr[rsrc1_q];
                    opb   <= b_sel;
                    prod  <= {{DATA_W{1'b0}}, b_sel};
                    cnt   <= '0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        prod <= {mul_add, prod[DATA_W-1:1]};
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= S_WB;
                        end
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    done        <= 1'b1;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                    if (op_illegal) begin
                        illegal <= 1'b1;
                    end else if (op_q == OP_MUL) begin
                        gpr[rdst_q] <= prod[DATA_W-1:0];
                        sgpr        <= mul_hi;
                        flags       <= mul_flags;
                    end else begin
                        gpr[rdst_q] <= alu_res;
                        flags       <= alu_flags;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_multicycle_exec.sv
// Directed bench for gpr_multicycle_exec: a table of instructions with hand-computed
// results, followed by hand-written back-to-back, busy-ignore and reset-during-MUL sequences.
module tb_gpr_multicycle_exec;

    logic        clk;
    logic        sys_rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [4:0]  instr_rdst;
    logic [4:0]  instr_rsrc1;
    logic [4:0]  instr_rsrc2;
    logic        instr_imm_mode;
    logic [15:0] instr_imm;
    logic        done;
    logic        illegal;
    logic [3:0]  flags;
    logic [15:0] sgpr;
    logic [4:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        im;
        logic [15:0] imm;
        logic [15:0] exp;
        logic [3:0]  fl;
        int          lat;
        logic [15:0] sg;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    gpr_multicycle_exec #(
        .DATA_W (16),
        .NUM_GPR(32),
        .IMM_W  (16)
    ) dut (
        .clk           (clk),
        .sys_rst       (sys_rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rdst    (instr_rdst),
        .instr_rsrc1   (instr_rsrc1),
        .instr_rsrc2   (instr_rsrc2),
        .instr_imm_mode(instr_imm_mode),
        .instr_imm     (instr_imm),
        .done          (done),
        .illegal       (illegal),
        .flags         (flags),
        .sgpr          (sgpr),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] op, input int rd, input int rs1, input int rs2,
                                input logic im, input logic [15:0] imm, input logic [15:0] exp,
                                input logic [3:0] fl, input int lat, input logic [15:0] sg,
                                input logic ill);
        vec_t v;
        v.op  = op;
        v.rd  = 5'(rd);
        v.rs1 = 5'(rs1);
        v.rs2 = 5'(rs2);
        v.im  = im;
        v.imm = imm;
        v.exp = exp;
        v.fl  = fl;
        v.lat = lat;
        v.sg  = sg;
        v.ill = ill;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_gpr(input logic [4:0] addr, output logic [15:0] val);
        dbg_addr = addr;
        #1;
        val = dbg_data;
    endtask

    // Drives one instruction, waits for the accept edge, then scrambles the fields.
    task automatic apply_stimulus(input vec_t v, output int waited);
        @(negedge clk);
        instr_op       = v.op;
        instr_rdst     = v.rd;
        instr_rsrc1    = v.rs1;
        instr_rsrc2    = v.rs2;
        instr_imm_mode = v.im;
        instr_imm      = v.imm;
        instr_valid    = 1'b1;
        waited         = 0;
        while (!instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) check_output("accept timeout", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        instr_valid    = 1'b0;
        instr_op       = 5'($urandom);
        instr_rdst     = 5'($urandom);
        instr_rsrc1    = 5'($urandom);
        instr_rsrc2    = 5'($urandom);
        instr_imm_mode = 1'($urandom);
        instr_imm      = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int lat, input logic ill,
                             input logic [3:0] fl, input logic [15:0] sg);
        int seen = 0;
        for (int k = 1; k <= lat + 4; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = k;
                break;
            end
        end
        check_output({tag, " done latency"}, 32'(seen), 32'(lat));
        if (seen != 0) begin
            check_output({tag, " illegal"}, 32'(illegal), 32'(ill));
            check_output({tag, " flags"}, 32'(flags), 32'(fl));
            check_output({tag, " sgpr"}, 32'(sgpr), 32'(sg));
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          w;
        logic [15:0] val;
        string       tag;
        v   = vecs[idx];
        tag = $sformatf("vec%0d op%0d", idx, v.op);
        apply_stimulus(v, w);
        wait_done(tag, v.lat, v.ill, v.fl, v.sg);
        @(posedge clk);
        #1;
        check_output({tag, " done pulse width"}, 32'(done), 32'd0);
        read_gpr(v.rd, val);
        check_output({tag, " gpr"}, 32'(val), 32'(v.exp));
    endtask

    initial begin
        vec_t        v;
        int          w;
        int          extra;
        logic [15:0] val;

        sys_rst        = 1'b1;
        instr_valid    = 1'b0;
        instr_op       = '0;
        instr_rdst     = '0;
        instr_rsrc1    = '0;
        instr_rsrc2    = '0;
        instr_imm_mode = 1'b0;
        instr_imm      = '0;
        dbg_addr       = '0;

        //             op  rd rs1 rs2 im imm       exp       fl    lat sgpr      ill
        vecs.push_back(mk(1,  2,  0,  0, 1, 16'h0002, 16'h0002, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(2,  0,  2,  0, 1, 16'h0004, 16'h0006, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(1,  1,  0,  0, 1, 16'h0003, 16'h0003, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(1,  2,  0,  0, 1, 16'h0005, 16'h0005, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(3,  4,  1,  2, 0, 16'h0000, 16'hFFFE, 4'h2, 3,  16'h0000, 0));
        vecs.push_back(mk(1,  6,  0,  0, 1, 16'h8000, 16'h8000, 4'h2, 3,  16'h0000, 0));
        vecs.push_back(mk(1,  7,  0,  0, 1, 16'h8002, 16'h8002, 4'h2, 3,  16'h0000, 0));
        vecs.push_back(mk(2,  8,  6,  7, 0, 16'h0000, 16'h0002, 4'hC, 3,  16'h0000, 0));
        vecs.push_back(mk(2,  9, 10, 11, 0, 16'h0000, 16'h0000, 4'h1, 3,  16'h0000, 0));
        vecs.push_back(mk(5, 10,  2,  0, 1, 16'h000A, 16'h000F, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(6, 11,  7,  0, 1, 16'h00FF, 16'h0002, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(7, 12,  6,  7, 0, 16'h0000, 16'h0002, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(8, 13,  6,  7, 0, 16'h0000, 16'hFFFD, 4'h2, 3,  16'h0000, 0));
        vecs.push_back(mk(9, 14,  6,  0, 1, 16'h8000, 16'h7FFF, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(10, 15, 9,  9, 0, 16'h0000, 16'hFFFF, 4'h2, 3,  16'h0000, 0));
        vecs.push_back(mk(11, 16, 10, 0, 0, 16'h0000, 16'hFFF0, 4'h2, 3,  16'h0000, 0));
        vecs.push_back(mk(3, 17,  2,  2, 0, 16'h0000, 16'h0000, 4'h5, 3,  16'h0000, 0));
        vecs.push_back(mk(3, 18,  6,  0, 1, 16'h0001, 16'h7FFF, 4'hC, 3,  16'h0000, 0));
        vecs.push_back(mk(2, 19, 15,  0, 1, 16'h0001, 16'h0000, 4'h5, 3,  16'h0000, 0));
        vecs.push_back(mk(1, 20,  0,  0, 1, 16'h1234, 16'h1234, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(1, 21,  0,  0, 1, 16'h0100, 16'h0100, 4'h0, 3,  16'h0000, 0));
        vecs.push_back(mk(4, 22, 20, 21, 0, 16'h0000, 16'h3400, 4'hC, 18, 16'h0012, 0));
        vecs.push_back(mk(0,  5,  0,  0, 0, 16'h0000, 16'h0012, 4'h0, 3,  16'h0012, 0));
        vecs.push_back(mk(4, 23,  9, 20, 0, 16'h0000, 16'h0000, 4'h1, 18, 16'h0000, 0));
        vecs.push_back(mk(4, 24, 15, 15, 0, 16'h0000, 16'h0001, 4'hE, 18, 16'hFFFE, 0));
        vecs.push_back(mk(12, 0,  2,  2, 0, 16'h0000, 16'h0006, 4'hE, 3,  16'hFFFE, 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("reset ready", 32'(instr_ready), 32'd1);
        check_output("reset done", 32'(done), 32'd0);
        check_output("reset illegal", 32'(illegal), 32'd0);
        check_output("reset flags", 32'(flags), 32'd0);
        check_output("reset sgpr", 32'(sgpr), 32'd0);
        read_gpr(5'd0, val);
        check_output("reset gpr0", 32'(val), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i);
        end

        // Illegal op 20 followed immediately by a MOV accepted the cycle after WB.
        v = mk(20, 7, 2, 3, 0, 16'h0000, 16'h8002, 4'hE, 3, 16'hFFFE, 1);
        apply_stimulus(v, w);
        wait_done("illegal op20", 3, 1'b1, 4'hE, 16'hFFFE);
        check_output("b2b ready in done cycle", 32'(instr_ready), 32'd1);
        v = mk(1, 25, 0, 0, 1, 16'h0077, 16'h0077, 4'h0, 3, 16'hFFFE, 0);
        apply_stimulus(v, w);
        check_output("b2b accept wait", 32'(w), 32'd0);
        check_output("b2b ready dropped", 32'(instr_ready), 32'd0);

        // A valid raised while busy must be dropped; two edges of the MOV remain after this.
        @(negedge clk);
        instr_op       = 5'd1;
        instr_rdst     = 5'd26;
        instr_imm_mode = 1'b1;
        instr_imm      = 16'h0055;
        instr_valid    = 1'b1;
        @(posedge clk);
        #1;
        check_output("busy ready low", 32'(instr_ready), 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_done("b2b mov", 2, 1'b0, 4'h0, 16'hFFFE);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check_output("busy valid ignored done count", 32'(extra), 32'd0);
        read_gpr(5'd25, val);
        check_output("b2b mov gpr25", 32'(val), 32'h0077);
        read_gpr(5'd26, val);
        check_output("busy valid ignored gpr26", 32'(val), 32'd0);
        read_gpr(5'd7, val);
        check_output("illegal gpr7 unchanged", 32'(val), 32'h8002);
        read_gpr(5'd0, val);
        check_output("illegal gpr0 unchanged", 32'(val), 32'h0006);

        // Reset in the middle of MUL EXEC discards the instruction.
        v = mk(4, 27, 20, 21, 0, 16'h0000, 16'h3400, 4'hC, 18, 16'h0012, 0);
        apply_stimulus(v, w);
        repeat (8) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid-mul reset ready", 32'(instr_ready), 32'd1);
        check_output("mid-mul reset done", 32'(done), 32'd0);
        check_output("mid-mul reset flags", 32'(flags), 32'd0);
        check_output("mid-mul reset sgpr", 32'(sgpr), 32'd0);
        for (int r = 0; r < 32; r++) begin
            read_gpr(5'(r), val);
            check_output($sformatf("mid-mul reset gpr%0d", r), 32'(val), 32'd0);
        end
        extra = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check_output("mid-mul reset no late done", 32'(extra), 32'd0);
        read_gpr(5'd27, val);
        check_output("mid-mul reset gpr27", 32'(val), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
